alien_formation: RTL and testbench
==================================

ALIEN_FORMATION -- requirements
Module: alien_formation

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  COLS 8 columns in formation; ROWS 4 rows in formation
  CELL_W 32 cell pitch in x, pixels, power of two; CELL_H 32 cell pitch in y, pixels, power of two
  SPRITE_W 24 drawn width per cell; SPRITE_H 16 drawn height per cell
  START_X 100, START_Y 40 formation origin (top-left of cell 0,0) after reset
  X_MIN 10, X_MAX 629, Y_MAX 450 playfield limits
  X_STEP 3 x move per step; Y_STEP 16 drop per step
  BASE_PERIOD 8 frames per step while more than half of the aliens are alive
REQ-002 SHALL have ports (name, direction, width, meaning):
  Clk  in  1  system clock
  Reset  in  1  synchronous, active-high reset; clock is Clk
  frame_clk  in  1  vertical-sync-rate strobe, asynchronous to motion logic
  hit_valid  in  1  one-Clk hit request
  hit_row  in  clog2(ROWS)  row index of hit target
  hit_col  in  clog2(COLS)  column index of hit target
  DrawX, DrawY  in  10 each  current pixel coordinate
  is_alien  out  1  current pixel lies on a live sprite
  alien_row, alien_col  out  clog2(ROWS), clog2(COLS)  cell under pixel when is_alien=1, else 0
  form_x, form_y  out  10 each  formation origin
  alive_count  out  clog2(ROWS*COLS+1)  live aliens
  all_dead  out  1  alive_count==0
  is_oob  out  1  lowest live row has reached Y_MAX
  dir  out  2  0=LEFT, 1=RIGHT, 2=DROP, 3=HALT

Function
REQ-003 SHALL register frame_clk once and generate frame_tick, a 1-Clk pulse per rising edge of frame_clk, 2 Clk after the edge.
REQ-004 SHALL hold an alive mask of ROWS*COLS bits; hit_valid with an in-range, live target clears that bit on the next Clk edge and decrements alive_count by 1.
REQ-005 A hit on a dead or out-of-range target SHALL be ignored; alive_count SHALL be unchanged.
REQ-006 Step period SHALL be BASE_PERIOD frames if alive_count > ROWS*COLS/2, BASE_PERIOD/2 frames if alive_count > ROWS*COLS/4, otherwise 1 frame; a frame counter SHALL count frame_tick and fire step_tick on reaching the period, then clear.
REQ-007 Leftmost/rightmost live column (lc/rc) and lowest live row (br) SHALL be derived combinationally from the mask; left edge = form_x + lc*CELL_W, right edge = form_x + rc*CELL_W + SPRITE_W - 1.
REQ-008 FSM on step_tick:
  RIGHT: if right edge + X_STEP > X_MAX, go to DROP with last=RIGHT and x unchanged; else form_x += X_STEP.
  LEFT: if left edge < X_MIN + X_STEP, go to DROP with last=LEFT; else form_x -= X_STEP.
  DROP: form_y += Y_STEP, then go to the direction opposite of last.
REQ-009 HALT SHALL be entered on the Clk after all_dead or is_oob is asserted, from any state; HALT SHALL freeze form_x, form_y and the frame counter until Reset.
REQ-010 is_oob SHALL be 1 when form_y + br*CELL_H + SPRITE_H - 1 >= Y_MAX and at least one alien is alive.
REQ-011 A hit and a step_tick in the same Clk SHALL both take effect; the boundary test SHALL use the pre-hit mask.
REQ-012 is_alien SHALL be combinational:
  - DrawX >= form_x and DrawY >= form_y
  - col = (DrawX-form_x)/CELL_W < COLS and row = (DrawY-form_y)/CELL_H < ROWS
  - in-cell offsets < SPRITE_W and < SPRITE_H
  - mask[row][col] = 1
REQ-013 All arithmetic SHALL be 10-bit unsigned with comparisons done at 11 bits, so that no wrap-around occurs at X_MAX or Y_MAX.

Reset
REQ-014 On Reset:
  - form_x=START_X, form_y=START_Y, all mask bits 1, alive_count=ROWS*COLS
  - dir=RIGHT, frame counter 0, frame_tick pipeline cleared
  - all_dead=0, is_oob=0
REQ-015 Reset asserted mid-step or in HALT SHALL restore the REQ-014 state on the next Clk.

Verification
REQ-016 Reset, then 8 frame_clk edges -> form_x 100->103 after 8th edge, dir=1, form_y=40.
REQ-017 Run with all alive -> form_x advances to 382, next step dir=2 (x stays 382), following step form_y=56 and dir=0.
REQ-018 hit_valid row1 col2 -> alive_count 32->31, pixel (form_x+69, form_y+37) gives is_alien=0; same hit repeated -> count stays 31.
REQ-019 Kill column 7 (4 hits) -> DROP occurs only when form_x > 411; kill 17 aliens -> period 4 frames; kill 24 -> period 1.
REQ-020 Kill all 32 -> all_dead=1 the Clk after the last hit, dir=3, form_x/form_y frozen over 20 frames; Reset -> form_x=100, alive_count=32.
REQ-021 Descend until form_y + 3*32 + 15 >= 450 -> is_oob=1, dir=3 next Clk; hit during HALT still clears its mask bit.

Source files
------------

// File: rtl/alien_formation.sv
`default_nettype none
// ============================================================================
// alien_formation: alive mask, stepped formation motion and pixel hit-test.
// Rev 1.0
// ============================================================================
module alien_formation #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int CELL_W      = 32,
  parameter int CELL_H      = 32,
  parameter int SPRITE_W    = 24,
  parameter int SPRITE_H    = 16,
  parameter int START_X     = 100,
  parameter int START_Y     = 40,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 629,
  parameter int Y_MAX       = 450,
  parameter int X_STEP      = 3,
  parameter int Y_STEP      = 16,
  parameter int BASE_PERIOD = 8
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic                             hit_valid,
  input  logic [$clog2(ROWS)-1:0]          hit_row,
  input  logic [$clog2(COLS)-1:0]          hit_col,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  output logic                             is_alien,
  output logic [$clog2(ROWS)-1:0]          alien_row,
  output logic [$clog2(COLS)-1:0]          alien_col,
  output logic [9:0]                       form_x,
  output logic [9:0]                       form_y,
  output logic [$clog2(ROWS*COLS+1)-1:0]   alive_count,
  output logic                             all_dead,
  output logic                             is_oob,
  output logic [1:0]                       dir
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int FC_W  = $clog2(BASE_PERIOD + 1);
  localparam int CW_SH = $clog2(CELL_W);
  localparam int CH_SH = $clog2(CELL_H);

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } dir_t;

  logic             frame_sync_q, frame_sync_d;
  logic             frame_prev_q, frame_prev_d;
  logic             frame_tick_q, frame_tick_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  dir_t             state_q, state_d;
  dir_t             last_q, last_d;
  logic [9:0]       form_x_q, form_x_d;
  logic [9:0]       form_y_q, form_y_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] alive_q, alive_d;

  logic [COL_W-1:0] lc, rc;
  logic [ROW_W-1:0] br;
  logic [10:0]      left_edge, right_edge, bottom_edge;
  logic             right_block, left_block;
  logic [FC_W-1:0]  period;
  logic [FC_W:0]    cnt_inc;
  logic             step_tick;
  logic             hit_ok;
  logic [IDX_W-1:0] hit_idx;
  logic [9:0]       dx, dy, pix_col, pix_row;
  logic             in_cell;
  logic [IDX_W-1:0] pix_idx;

  // Rising-edge detect on the sampled vsync strobe; the tick is itself registered.
  always_comb begin
    frame_sync_d = frame_clk;
    frame_prev_d = frame_sync_q;
    frame_tick_d = frame_sync_q & ~frame_prev_q;
  end

  always_comb begin
    lc = '0;
    rc = '0;
    br = '0;
    for (int c = COLS - 1; c >= 0; c--)
      for (int r = 0; r < ROWS; r++)
        if (mask_q[r*COLS + c]) lc = COL_W'(c);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (mask_q[r*COLS + c]) rc = COL_W'(c);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mask_q[r*COLS + c]) br = ROW_W'(r);
  end

  // Edges are widened to 11 bits so tests near the playfield limits cannot wrap.
  always_comb begin
    left_edge   = {1'b0, form_x_q} + (11'(lc) << CW_SH);
    right_edge  = {1'b0, form_x_q} + (11'(rc) << CW_SH) + 11'(SPRITE_W - 1);
    bottom_edge = {1'b0, form_y_q} + (11'(br) << CH_SH) + 11'(SPRITE_H - 1);
    right_block = (right_edge + 11'(X_STEP)) > 11'(X_MAX);
    left_block  = left_edge < 11'(X_MIN + X_STEP);
    all_dead    = (alive_q == '0);
    is_oob      = (bottom_edge >= 11'(Y_MAX)) && !all_dead;
  end

  always_comb begin
    if (alive_q > CNT_W'(N / 2))
      period = FC_W'(BASE_PERIOD);
    else if (alive_q > CNT_W'(N / 4))
      period = FC_W'(BASE_PERIOD / 2);
    else
      period = FC_W'(1);
    cnt_inc     = {1'b0, frame_cnt_q} + {{FC_W{1'b0}}, 1'b1};
    step_tick   = frame_tick_q && (state_q != HALT) && (cnt_inc >= {1'b0, period});
    frame_cnt_d = frame_cnt_q;
    if (frame_tick_q && state_q != HALT)
      frame_cnt_d = step_tick ? '0 : cnt_inc[FC_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    form_x_d = form_x_q;
    form_y_d = form_y_q;
    if (step_tick) begin
      unique case (state_q)
        RIGHT: begin
          if (right_block) begin
            state_d = DROP;
            last_d  = RIGHT;
          end else begin
            form_x_d = form_x_q + 10'(X_STEP);
          end
        end
        LEFT: begin
          if (left_block) begin
            state_d = DROP;
            last_d  = LEFT;
          end else begin
            form_x_d = form_x_q - 10'(X_STEP);
          end
        end
        DROP: begin
          form_y_d = form_y_q + 10'(Y_STEP);
          state_d  = (last_q == RIGHT) ? LEFT : RIGHT;
        end
        default: ;
      endcase
    end
    if (all_dead || is_oob)
      state_d = HALT;
  end

  always_comb begin
    hit_ok  = hit_valid
              && ({1'b0, hit_row} < (ROW_W + 1)'(ROWS))
              && ({1'b0, hit_col} < (COL_W + 1)'(COLS));
    hit_idx = IDX_W'(32'(hit_row) * COLS + 32'(hit_col));
    mask_d  = mask_q;
    alive_d = alive_q;
    if (hit_ok) begin
      if (mask_q[hit_idx]) begin
        mask_d[hit_idx] = 1'b0;
        alive_d         = alive_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    dx      = DrawX - form_x_q;
    dy      = DrawY - form_y_q;
    pix_col = dx >> CW_SH;
    pix_row = dy >> CH_SH;
    in_cell = (DrawX >= form_x_q) && (DrawY >= form_y_q)
              && (pix_col < 10'(COLS)) && (pix_row < 10'(ROWS))
              && ((dx & 10'(CELL_W - 1)) < 10'(SPRITE_W))
              && ((dy & 10'(CELL_H - 1)) < 10'(SPRITE_H));
    pix_idx   = '0;
    is_alien  = 1'b0;
    alien_row = '0;
    alien_col = '0;
    if (in_cell) begin
      pix_idx = IDX_W'(32'(pix_row) * COLS + 32'(pix_col));
      if (mask_q[pix_idx]) begin
        is_alien  = 1'b1;
        alien_row = ROW_W'(pix_row);
        alien_col = COL_W'(pix_col);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      state_q      <= RIGHT;
      last_q       <= RIGHT;
      form_x_q     <= 10'(START_X);
      form_y_q     <= 10'(START_Y);
      mask_q       <= '1;
      alive_q      <= CNT_W'(N);
    end else begin
      frame_sync_q <= frame_sync_d;
      frame_prev_q <= frame_prev_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      state_q      <= state_d;
      last_q       <= last_d;
      form_x_q     <= form_x_d;
      form_y_q     <= form_y_d;
      mask_q       <= mask_d;
      alive_q      <= alive_d;
    end
  end

  assign form_x      = form_x_q;
  assign form_y      = form_y_q;
  assign alive_count = alive_q;
  assign dir         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_formation.sv
`default_nettype none
// tb_alien_formation: randomized bench checked against a frame-level model
// of the formation (positions, alive mask, direction, step period).
module tb_alien_formation;

  localparam int ROWS = 4, COLS = 8, CELL_W = 32, CELL_H = 32;
  localparam int SPRITE_W = 24, SPRITE_H = 16;
  localparam int X_MIN = 10, X_MAX = 629, Y_MAX = 450;
  localparam int X_STEP = 3, Y_STEP = 16, BASE_PERIOD = 8;
  localparam int D_LEFT = 0, D_RIGHT = 1, D_DROP = 2, D_HALT = 3;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, hit_valid;
  logic [1:0] hit_row;
  logic [2:0] hit_col;
  logic [9:0] DrawX, DrawY;
  logic       is_alien;
  logic [1:0] alien_row;
  logic [2:0] alien_col;
  logic [9:0] form_x, form_y;
  logic [5:0] alive_count;
  logic       all_dead, is_oob;
  logic [1:0] dir;

  alien_formation dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_alien(is_alien), .alien_row(alien_row), .alien_col(alien_col),
    .form_x(form_x), .form_y(form_y), .alive_count(alive_count),
    .all_dead(all_dead), .is_oob(is_oob), .dir(dir)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mx, my, mdir, mlast, mcnt, malive;
  bit mmask [ROWS][COLS];

  function automatic void model_reset();
    mx = 100; my = 40; mdir = D_RIGHT; mlast = D_RIGHT; mcnt = 0; malive = ROWS * COLS;
    foreach (mmask[r, c]) mmask[r][c] = 1'b1;
  endfunction

  function automatic int m_lc();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (mmask[r][c]) return c;
    return 0;
  endfunction

  function automatic int m_rc();
    for (int c = COLS - 1; c >= 0; c--)
      for (int r = 0; r < ROWS; r++)
        if (mmask[r][c]) return c;
    return 0;
  endfunction

  function automatic int m_br();
    for (int r = ROWS - 1; r >= 0; r--)
      for (int c = 0; c < COLS; c++)
        if (mmask[r][c]) return r;
    return 0;
  endfunction

  function automatic bit m_oob();
    return (malive > 0) && (my + m_br() * CELL_H + SPRITE_H - 1 >= Y_MAX);
  endfunction

  function automatic void model_step();
    case (mdir)
      D_RIGHT:
        if (mx + m_rc() * CELL_W + SPRITE_W - 1 + X_STEP > X_MAX) begin
          mdir = D_DROP; mlast = D_RIGHT;
        end else mx += X_STEP;
      D_LEFT:
        if (mx + m_lc() * CELL_W < X_MIN + X_STEP) begin
          mdir = D_DROP; mlast = D_LEFT;
        end else mx -= X_STEP;
      D_DROP: begin
        my += Y_STEP;
        mdir = (mlast == D_RIGHT) ? D_LEFT : D_RIGHT;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_frame();
    int period;
    if (mdir == D_HALT) return;
    period = (malive > ROWS * COLS / 2) ? BASE_PERIOD :
             (malive > ROWS * COLS / 4) ? BASE_PERIOD / 2 : 1;
    if (mcnt + 1 >= period) begin
      mcnt = 0;
      model_step();
    end else mcnt++;
  endfunction

  function automatic void model_hit(input int r, input int c);
    if (mmask[r][c]) begin
      mmask[r][c] = 1'b0;
      malive--;
    end
  endfunction

  function automatic void model_settle();
    if (mdir != D_HALT && (malive == 0 || m_oob())) mdir = D_HALT;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge Clk) begin Reset = 1'b1; frame_clk = 1'b0; hit_valid = 1'b0; end
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b0;
    model_reset();
  endtask

  task automatic do_frame(input bit with_hit, input int r, input int c);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    // hit lands in the same Clk as the step
    @(negedge Clk) if (with_hit) begin hit_valid = 1'b1; hit_row = 2'(r); hit_col = 3'(c); end
    @(negedge Clk) hit_valid = 1'b0;
    @(negedge Clk);
    model_frame();
    if (with_hit) model_hit(r, c);
    model_settle();
  endtask

  task automatic do_hit(input int r, input int c);
    @(negedge Clk) begin hit_valid = 1'b1; hit_row = 2'(r); hit_col = 3'(c); end
    @(negedge Clk) hit_valid = 1'b0;
    @(negedge Clk);
    model_hit(r, c);
    model_settle();
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_x"}, form_x, mx);
    check({tag, "_y"}, form_y, my);
    check({tag, "_dir"}, dir, mdir);
    check({tag, "_alive"}, alive_count, malive);
    check({tag, "_dead"}, all_dead, (malive == 0));
    check({tag, "_oob"}, is_oob, m_oob());
  endtask

  task automatic probe(input int x, input int y);
    int col, row, ea, er, ec;
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
    ea = 0; er = 0; ec = 0;
    if (x >= mx && y >= my) begin
      col = (x - mx) / CELL_W;
      row = (y - my) / CELL_H;
      if (col < COLS && row < ROWS && (x - mx) % CELL_W < SPRITE_W &&
          (y - my) % CELL_H < SPRITE_H && mmask[row][col]) begin
        ea = 1; er = row; ec = col;
      end
    end
    check("pix_alien", is_alien, ea);
    check("pix_row", alien_row, er);
    check("pix_col", alien_col, ec);
  endtask

  task automatic probe_random(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
      end else begin
        x = mx + int'($urandom_range(0, 280)) - 8;
        y = my + int'($urandom_range(0, 140)) - 8;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (x > 1023) x = 1023;
        if (y > 1023) y = 1023;
      end
      probe(x, y);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_x"}, form_x, 100);
    check({tag, "_y"}, form_y, 40);
    check({tag, "_dir"}, dir, 1);
    check({tag, "_alive"}, alive_count, 32);
    check({tag, "_dead"}, all_dead, 0);
    check({tag, "_oob"}, is_oob, 0);
  endtask

  // Frames until the DUT's visible position/direction changes.
  task automatic measure_period(output int n);
    logic [9:0] sx, sy;
    logic [1:0] sd;
    n = 0;
    sx = form_x; sy = form_y; sd = dir;
    for (int i = 0; i < 20; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("per");
      n++;
      if (form_x !== sx || form_y !== sy || dir !== sd) break;
    end
  endtask

  task automatic kill_random_until(input int target, input int max_col);
    int r, c;
    for (int k = 0; k < 2000 && malive > target; k++) begin
      r = int'($urandom_range(0, ROWS - 1));
      c = int'($urandom_range(0, max_col));
      if (mmask[r][c]) begin
        do_hit(r, c);
        compare_state("kill");
      end
    end
    check("kill_count", alive_count, target);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r, c;
    Reset = 1'b0; frame_clk = 1'b0; hit_valid = 1'b0;
    hit_row = '0; hit_col = '0; DrawX = '0; DrawY = '0;

    do_reset();
    reset_checks("rst0");
    probe_random(8);

    // First step after eight frames.
    for (int i = 0; i < 8; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("f8");
    end
    check("first_step_x", form_x, 103);
    check("first_step_dir", dir, 1);
    check("first_step_y", form_y, 40);

    // Full-width sweep to the right boundary, then drop.
    for (int i = 0; i < 2000 && mdir != D_DROP; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("sweep");
    end
    check("sweep_x", form_x, 382);
    check("sweep_dir", dir, 2);
    for (int i = 0; i < 20 && mdir == D_DROP; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("drop");
    end
    check("drop_y", form_y, 56);
    check("drop_dir", dir, 0);
    check("drop_x", form_x, 382);

    // Hit, dead pixel, repeated hit.
    do_hit(1, 2);
    compare_state("hit");
    check("hit_count", alive_count, 31);
    probe(mx + 69, my + 37);
    check("hit_pix", is_alien, 0);
    do_hit(1, 2);
    check("rehit_count", alive_count, 31);
    probe_random(16);

    // Reset in the middle of a frame.
    @(negedge Clk) frame_clk = 1'b1;
    do_reset();
    reset_checks("rst1");

    // Narrower formation sweeps further right.
    for (int i = 0; i < ROWS; i++) begin
      do_hit(i, 7);
      compare_state("col7");
    end
    for (int i = 0; i < 2000 && mdir != D_DROP; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("sweep7");
    end
    check("col7_drop_x", form_x, 412);
    check("col7_drop_dir", dir, 2);

    // 17 killed -> 4-frame period; 24 killed -> 1-frame period.
    kill_random_until(15, 6);
    measure_period(n);
    measure_period(n);
    check("period4", n, 4);
    kill_random_until(8, 7);
    measure_period(n);
    measure_period(n);
    check("period1", n, 1);

    // Random play with occasional hits (some same-Clk as a step) until halt.
    for (int i = 0; i < 8000 && mdir != D_HALT; i++) begin
      r = int'($urandom_range(0, ROWS - 1));
      c = int'($urandom_range(0, COLS - 1));
      if (malive > 3 && $urandom_range(0, 9) == 0) begin
        do_frame(1'b1, r, c);
      end else if (malive > 3 && $urandom_range(0, 19) == 0) begin
        do_hit(r, c);
      end else begin
        do_frame(1'b0, 0, 0);
      end
      compare_state("rnd");
      if (i % 32 == 0) probe_random(2);
    end
    check("oob_flag", is_oob, 1);
    check("oob_halt", dir, 3);

    // A hit during HALT still clears its bit; position stays frozen.
    begin : halt_hit
      int hr, hc;
      hr = 0; hc = 0;
      foreach (mmask[i, j]) if (mmask[i][j]) begin hr = i; hc = j; end
      n = malive;
      do_hit(hr, hc);
      compare_state("halthit");
      check("halthit_count", alive_count, n - 1);
      check("halthit_dir", dir, 3);
      probe(mx + hc * CELL_W + 1, my + hr * CELL_H + 1);
    end
    for (int i = 0; i < 5; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("haltfrz");
    end

    // Reset from HALT, then kill everything.
    do_reset();
    reset_checks("rst2");
    for (int i = 0; i < 10; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("pre");
    end
    for (int i = 0; i < ROWS * COLS; i++) begin
      do_hit(i / COLS, i % COLS);
      if (i % 5 == 0) do_hit(i / COLS, i % COLS);
      compare_state("killall");
    end
    check("dead_flag", all_dead, 1);
    check("dead_dir", dir, 3);
    for (int i = 0; i < 20; i++) begin
      do_frame(1'b0, 0, 0);
      compare_state("deadfrz");
    end
    check("dead_x", form_x, 103);
    check("dead_y", form_y, 40);
    probe_random(4);
    do_reset();
    reset_checks("rst3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
